// File: rtl/fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_collector
// Purpose  : Receiving end of the FPU exception path. For each operation it
//            picks the final IEEE-754 single result (arith or exception value)
//            and classifies it into {NV,DZ,OF,EX}. It buffers result, opcode
//            and flags in a small FIFO and hands them downstream over
//            valid/ready. It also keeps sticky flags and a saturating
//            exception counter for software readback.
// Ports    : clk, rst_n                  - clock (rising), async active-low reset
//            in_valid/in_ready           - upstream handshake (in_ready = !full)
//            in_opcode, in_sel           - opcode; 1 = arith value, 0 = exc value
//            in_exc_value/in_arith_value - candidate results
//            out_valid/out_ready         - downstream handshake
//            out_result/out_opcode/out_flags - head entry, zero when !out_valid
//            sticky_flags, exc_count     - accumulated over consumed results
//            flag_clr                    - synchronous clear of sticky state
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   in_opcode,
  input  logic                  in_sel,
  input  logic [DATA_WIDTH-1:0] in_exc_value,
  input  logic [DATA_WIDTH-1:0] in_arith_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [OP_WIDTH-1:0]   out_opcode,
  output logic [3:0]            out_flags,
  output logic [3:0]            sticky_flags,
  input  logic                  flag_clr,
  output logic [CNT_WIDTH-1:0]  exc_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]  C_FULL   = OCC_W'(FIFO_DEPTH);
  localparam logic [OP_WIDTH-1:0] C_OP_DIV = OP_WIDTH'(3);

  // Entry storage; not reset because the outputs are gated by out_valid.
  logic [DATA_WIDTH-1:0] mem_result [FIFO_DEPTH];
  logic [OP_WIDTH-1:0]   mem_opcode [FIFO_DEPTH];
  logic [3:0]            mem_flags  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic [DATA_WIDTH-1:0] sel_result;
  logic [7:0]            sel_exp;
  logic [22:0]           sel_man;
  logic [3:0]            push_flags;
  logic                  push;
  logic                  pop;

  // Result selection and classification, captured only at push.
  always_comb begin
    sel_result = in_sel ? in_arith_value : in_exc_value;
    sel_exp    = sel_result[30:23];
    sel_man    = sel_result[22:0];
    push_flags[0] = !in_sel;                                              // EX
    push_flags[1] = in_sel && (sel_exp == 8'hFF);                         // OF
    push_flags[2] = !in_sel && (in_opcode == C_OP_DIV) &&
                    (sel_exp == 8'hFF) && (sel_man == 23'd0);             // DZ
    push_flags[3] = !in_sel && (sel_exp == 8'hFF) && (sel_man != 23'd0);  // NV
  end

  // Occupancy is a register, so in_ready never depends on out_ready:
  // a full buffer refuses a push even while it is being popped.
  assign in_ready  = (occ != C_FULL);
  assign out_valid = (occ != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = out_valid ? mem_result[rd_ptr] : '0;
  assign out_opcode = out_valid ? mem_opcode[rd_ptr] : '0;
  assign out_flags  = out_valid ? mem_flags[rd_ptr]  : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= sel_result;
      mem_opcode[wr_ptr] <= in_opcode;
      mem_flags[wr_ptr]  <= push_flags;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  // On a pop coinciding with flag_clr the popped entry's contribution
  // survives: the clear applies to the old value, then the entry is added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_flags <= '0;
      exc_count    <= '0;
    end else if (pop) begin
      if (flag_clr) begin
        sticky_flags <= out_flags;
        exc_count    <= CNT_WIDTH'(out_flags[0]);
      end else begin
        sticky_flags <= sticky_flags | out_flags;
        if (out_flags[0] && (exc_count != '1))
          exc_count <= exc_count + CNT_WIDTH'(1);
      end
    end else if (flag_clr) begin
      sticky_flags <= '0;
      exc_count    <= '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_result_collector
// Purpose  : Scoreboard bench. Expected entries are queued when a push is
//            accepted and compared with the DUT head every cycle. A second
//            instance with a 2-bit counter shares the stimulus so that
//            counter saturation can be observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_result_collector;

  typedef struct {
    logic [31:0] r;
    logic [1:0]  op;
    logic [3:0]  f;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [1:0]  in_opcode;
  logic        in_sel;
  logic [31:0] in_exc_value, in_arith_value;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [31:0] out_result, out_result2;
  logic [1:0]  out_opcode, out_opcode2;
  logic [3:0]  out_flags, out_flags2;
  logic [3:0]  sticky_flags, sticky_flags2;
  logic        flag_clr;
  logic [15:0] exc_count;
  logic [1:0]  exc_count2;

  int errors = 0;
  int checks = 0;

  ent_t        mq[$];
  logic [3:0]  m_sticky;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  fpu_result_collector #(.DATA_WIDTH(32), .OP_WIDTH(2), .FIFO_DEPTH(2), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_sel(in_sel), .in_exc_value(in_exc_value),
    .in_arith_value(in_arith_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_opcode(out_opcode), .out_flags(out_flags),
    .sticky_flags(sticky_flags), .flag_clr(flag_clr), .exc_count(exc_count)
  );

  fpu_result_collector #(.DATA_WIDTH(32), .OP_WIDTH(2), .FIFO_DEPTH(2), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_sel(in_sel), .in_exc_value(in_exc_value),
    .in_arith_value(in_arith_value), .out_valid(out_valid2), .out_ready(out_ready),
    .out_result(out_result2), .out_opcode(out_opcode2), .out_flags(out_flags2),
    .sticky_flags(sticky_flags2), .flag_clr(flag_clr), .exc_count(exc_count2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input logic sel, input logic [31:0] exc,
                                           input logic [31:0] ar, input logic [1:0] op);
    logic [31:0] r;
    logic        nan, inf;
    r   = sel ? ar : exc;
    nan = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    inf = (r[30:23] == 8'hFF) && (r[22:0] == 0);
    return {!sel && nan, !sel && op == 2'b11 && inf, sel && (nan || inf), !sel};
  endfunction

  // Reference model: pop before push, push refused whenever the model is full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_sticky <= 4'd0;
      m_cnt    <= 16'd0;
      m_cnt2   <= 2'd0;
    end else begin
      bit   do_pop, do_push;
      ent_t e, h;
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() != 2);
      if (do_pop) begin
        h = mq.pop_front();
        if (flag_clr) begin
          m_sticky <= h.f;
          m_cnt    <= {15'd0, h.f[0]};
          m_cnt2   <= {1'b0, h.f[0]};
        end else begin
          m_sticky <= m_sticky | h.f;
          if (h.f[0] && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
          if (h.f[0] && m_cnt2 != 2'b11)   m_cnt2 <= m_cnt2 + 2'd1;
        end
      end else if (flag_clr) begin
        m_sticky <= 4'd0;
        m_cnt    <= 16'd0;
        m_cnt2   <= 2'd0;
      end
      if (do_push) begin
        e.r  = in_sel ? in_arith_value : in_exc_value;
        e.op = in_opcode;
        e.f  = exp_flags(in_sel, in_exc_value, in_arith_value, in_opcode);
        mq.push_back(e);
      end
    end
  end

  // Cycle monitor on the falling edge.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      chk("in_ready", 32'(in_ready), 32'(mq.size() != 2));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("result", out_result, mq[0].r);
        chk("opcode", 32'(out_opcode), 32'(mq[0].op));
        chk("flags", 32'(out_flags), 32'(mq[0].f));
      end else begin
        chk("idle_result", out_result, 32'd0);
        chk("idle_flags", 32'(out_flags), 32'd0);
      end
      chk("sticky", 32'(sticky_flags), 32'(m_sticky));
      chk("exc_count", 32'(exc_count), 32'(m_cnt));
      chk("exc_count_sat", 32'(exc_count2), 32'(m_cnt2));
    end
  end

  task automatic push_op(input logic sel, input logic [31:0] exc,
                         input logic [31:0] ar, input logic [1:0] op);
    bit acc;
    bit done;
    done           = 1'b0;
    in_sel         = sel;
    in_exc_value   = exc;
    in_arith_value = ar;
    in_opcode      = op;
    in_valid       = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      acc = (mq.size() != 2);
      @(posedge clk);
      #1;
      done = acc;
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && mq.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(out_valid), 32'd0);
  endtask

  task automatic chk_sticky(input string tag, input logic [3:0] s, input logic [15:0] c);
    chk({tag, "_sticky"}, 32'(sticky_flags), 32'(s));
    chk({tag, "_cnt"}, 32'(exc_count), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_opcode = 2'd0; in_sel = 1'b1;
    in_exc_value = 32'd0; in_arith_value = 32'd0; out_ready = 1'b1; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Normal result: 1.0, no flags
    push_op(1'b1, 32'h0, 32'h3F800000, 2'b00);
    drain();
    chk_sticky("t2", 4'b0000, 16'd0);

    // Exception inf on divide
    push_op(1'b0, 32'h7F800000, 32'h0, 2'b11);
    drain();
    chk_sticky("t3", 4'b0101, 16'd1);

    // Exception NaN on mul, then arith -inf
    push_op(1'b0, 32'h7FC00000, 32'h0, 2'b10);
    push_op(1'b1, 32'h0, 32'hFF800000, 2'b01);
    drain();
    chk_sticky("t4", 4'b1111, 16'd2);

    // Backpressure: third push must wait for out_ready
    out_ready = 1'b0;
    push_op(1'b1, 32'h0, 32'h40000000, 2'b00);
    push_op(1'b1, 32'h0, 32'h40400000, 2'b01);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      push_op(1'b1, 32'h0, 32'h40800000, 2'b10);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_sticky("t5", 4'b1111, 16'd2);

    // Reset mid-stream with two entries buffered
    out_ready = 1'b0;
    push_op(1'b1, 32'h0, 32'h41000000, 2'b00);
    push_op(1'b0, 32'h7F800000, 32'h0, 2'b11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_sticky", 32'(sticky_flags), 32'd0);
    chk("mid_rst_cnt", 32'(exc_count), 32'd0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // flag_clr coinciding with an EX pop, then counter saturation
    push_op(1'b0, 32'h7F800000, 32'h0, 2'b11);
    drain();
    chk_sticky("t6a", 4'b0101, 16'd1);
    push_op(1'b0, 32'h00000000, 32'h0, 2'b00);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk_sticky("t6_clr", 4'b0001, 16'd1);
    for (int k = 0; k < 5; k++) push_op(1'b0, 32'h3F800000, 32'h0, 2'(k));
    drain();
    chk_sticky("t6_cnt", 4'b0001, 16'd6);
    chk("t6_sat", 32'(exc_count2), 32'd3);

    // flag_clr alone
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk_sticky("clr_only", 4'b0000, 16'd0);
    chk("clr_only_sat", 32'(exc_count2), 32'd0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
